// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared fetch-stage types, pcsource encodings and reset vector
package if_fetch_ctrl_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {PCS_PC4, PCS_BPC, PCS_JPC, PCS_RST} pcsource_e;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_e;
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: instruction-memory read handshake plus decode-facing valid/ready bundle
interface if_fetch_ctrl_if;
    logic        imem_req, imem_ack, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, out_inst, out_pc, out_pc4;
    modport master(
        output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc4,
        input  imem_ack, imem_rdata, out_ready
    );
    modport slave(
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc4,
        output imem_ack, imem_rdata, out_ready
    );
endinterface

// File: rtl/if_fetch_ctrl_next_pc_mux.sv
// if_fetch_ctrl_next_pc_mux: 4:1 next-PC select, shared with the single-cycle datapath
module if_fetch_ctrl_next_pc_mux
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RST_PC = RESET_PC
) (
    input  logic [31:0] pc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  pcsource_e   sel,
    output logic [31:0] npc
);
    always_comb npc = sel == PCS_BPC ? bpc : sel == PCS_JPC ? jpc : sel == PCS_RST ? RST_PC : pc + 32'd4;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch sequencer owning the PC; issues imem reads and registers
// fetched words toward decode, discarding responses made stale by redirects.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   redirect,
    input  logic [1:0]             pcsource,
    input  logic [31:0]            bpc,
    input  logic [31:0]            jpc,
    if_fetch_ctrl_if.master        fb
);
    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt, mux_pc;
    logic         eff, accept, take;
    if_fetch_ctrl_next_pc_mux #(.RST_PC(RESET_PC)) u_mux (
        .pc(pc), .bpc(bpc), .jpc(jpc),
        .sel(eff ? pcsource_e'(pcsource) : PCS_PC4),
        .npc(mux_pc)
    );
    always_comb begin
        eff       = redirect && pcsource != 2'd0;
        accept    = fb.out_valid && fb.out_ready;
        take      = state == REQ && fb.imem_ack && !eff;
        pc_nxt    = (eff || (state == HOLD && accept)) ? mux_pc : pc;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     state_nxt = fb.imem_ack ? (eff ? REQ : HOLD) : (eff ? DRAIN : REQ);
            HOLD:    state_nxt = (eff || accept) ? REQ : HOLD;
            DRAIN:   state_nxt = fb.imem_ack ? REQ : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= clr ? IDLE : state_nxt;
    // imem_addr only moves when a fresh request starts, so it is stable while waiting for ack
    always_ff @(posedge clk) begin
        if (clr) begin
            pc           <= RESET_PC;
            fb.imem_req  <= 1'b0;
            fb.imem_addr <= RESET_PC;
            fb.out_valid <= 1'b0;
            fb.out_inst  <= '0;
            fb.out_pc    <= '0;
            fb.out_pc4   <= 32'd4;
        end else begin
            pc          <= pc_nxt;
            fb.imem_req <= state_nxt == REQ || state_nxt == DRAIN;
            if (state_nxt == REQ) fb.imem_addr <= pc_nxt;
            if (take) begin
                fb.out_valid <= 1'b1;
                fb.out_inst  <= fb.imem_rdata;
                fb.out_pc    <= pc;
                fb.out_pc4   <= pc + 32'd4;
            end else if (state == HOLD && (eff || accept)) begin
                fb.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed vector table, hand sequences, and randomized run
// against a stream-order reference model with a variable-latency memory.
module tb_if_fetch_ctrl;
    logic        clk = 1'b0, clr = 1'b1, redirect = 1'b0;
    logic [1:0]  pcsource = 2'd0;
    logic [31:0] bpc = '0, jpc = '0;
    int          total = 0, bad = 0;
    if_fetch_ctrl_if f();
    if_fetch_ctrl dut (.clk(clk), .clr(clr), .redirect(redirect), .pcsource(pcsource),
                       .bpc(bpc), .jpc(jpc), .fb(f));
    always #5 clk = ~clk;

    typedef struct {
        logic        clr, rd;
        logic [1:0]  pcs;
        logic [31:0] bpc, jpc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst, e_pc, e_pc4;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic rd, input logic [1:0] pcs, input logic [31:0] b,
                         input logic [31:0] j, input logic a, input logic [31:0] rdt, input logic r);
        clr = c; redirect = rd; pcsource = pcs; bpc = b; jpc = j;
        f.imem_ack = a; f.imem_rdata = rdt; f.out_ready = r;
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    logic [31:0] exp_pc, tgt, p_addr, held;
    logic        p_req, p_ack, p_clr, e;
    int          cnt, lat, nacc;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        //         clr rd pcs bpc           jpc           ack rdata         rdy  req addr          val inst          pc            pc4
        tv.push_back('{1, 0, 0, 0,            0,            0, 0,            0,   0, 0,            0, 0,            0,            4});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 0,            0, 0,            0,            4});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'hAAAA0000, 1,   0, 0,            1, 32'hAAAA0000, 0,            4});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 4,            0, 32'hAAAA0000, 0,            4});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'h11110004, 1,   0, 4,            1, 32'h11110004, 4,            8});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 8,            0, 32'h11110004, 4,            8});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'h22220008, 1,   0, 8,            1, 32'h22220008, 8,            32'hC});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            0,   0, 8,            1, 32'h22220008, 8,            32'hC});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            0,   0, 8,            1, 32'h22220008, 8,            32'hC});
        tv.push_back('{0, 1, 1, 32'hC,        32'h99,       0, 0,            1,   1, 32'hC,        0, 32'h22220008, 8,            32'hC});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'h3333000C, 0,   0, 32'hC,        1, 32'h3333000C, 32'hC,        32'h10});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 32'h10,       0, 32'h3333000C, 32'hC,        32'h10});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 32'h10,       0, 32'h3333000C, 32'hC,        32'h10});
        tv.push_back('{0, 1, 2, 32'h77,       32'h40,       0, 0,            1,   1, 32'h10,       0, 32'h3333000C, 32'hC,        32'h10});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 32'h10,       0, 32'h3333000C, 32'hC,        32'h10});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'hDEAD0010, 1,   1, 32'h40,       0, 32'h3333000C, 32'hC,        32'h10});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'h44440040, 1,   0, 32'h40,       1, 32'h44440040, 32'h40,       32'h44});
        tv.push_back('{0, 1, 0, 32'h123,      32'h456,      0, 0,            0,   0, 32'h40,       1, 32'h44440040, 32'h40,       32'h44});
        tv.push_back('{0, 1, 3, 32'h123,      32'h456,      0, 0,            1,   1, 0,            0, 32'h44440040, 32'h40,       32'h44});
        tv.push_back('{0, 1, 1, 32'hFFFFFFFC, 32'h8,        1, 32'hBAD00000, 1,   1, 32'hFFFFFFFC, 0, 32'h44440040, 32'h40,       32'h44});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'h5555FFFC, 1,   0, 32'hFFFFFFFC, 1, 32'h5555FFFC, 32'hFFFFFFFC, 0});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 0,            0, 32'h5555FFFC, 32'hFFFFFFFC, 0});
        tv.push_back('{1, 0, 0, 0,            0,            0, 0,            1,   0, 0,            0, 0,            0,            4});
        tv.push_back('{0, 0, 0, 0,            0,            0, 0,            1,   1, 0,            0, 0,            0,            4});
        tv.push_back('{1, 0, 0, 0,            0,            0, 0,            1,   0, 0,            0, 0,            0,            4});
        tv.push_back('{0, 1, 2, 32'h11,       32'h80,       0, 0,            1,   1, 32'h80,       0, 0,            0,            4});
        tv.push_back('{0, 0, 0, 0,            0,            1, 32'h66660080, 1,   0, 32'h80,       1, 32'h66660080, 32'h80,       32'h84});
        tick();
        foreach (tv[i]) begin
            drive(tv[i].clr, tv[i].rd, tv[i].pcs, tv[i].bpc, tv[i].jpc, tv[i].ack, tv[i].rdata, tv[i].rdy);
            tick();
            chk($sformatf("v%0d_req", i), 32'(f.imem_req), 32'(tv[i].e_req));
            chk($sformatf("v%0d_addr", i), f.imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(f.out_valid), 32'(tv[i].e_val));
            chk($sformatf("v%0d_inst", i), f.out_inst, tv[i].e_inst);
            chk($sformatf("v%0d_pc", i), f.out_pc, tv[i].e_pc);
            chk($sformatf("v%0d_pc4", i), f.out_pc4, tv[i].e_pc4);
        end

        // ack latency 3 then decode stalls four cycles in HOLD
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lat_req_held", 32'(f.imem_req), 1);
            chk("lat_addr_stable", f.imem_addr, 0);
            chk("lat_no_valid", 32'(f.out_valid), 0);
        end
        f.imem_ack = 1'b1; f.imem_rdata = 32'h0BAD_F00D; tick();
        f.imem_ack = 1'b0; f.imem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 32'(f.out_valid), 1);
            chk("stall_inst", f.out_inst, 32'h0BAD_F00D);
            chk("stall_no_req", 32'(f.imem_req), 0);
            tick();
        end
        f.out_ready = 1'b1; tick();
        chk("stall_release_req", 32'(f.imem_req), 1);
        chk("stall_release_addr", f.imem_addr, 4);
        chk("stall_release_valid", 32'(f.out_valid), 0);

        // randomized run: delivered stream must follow pc+4 order, restarting at each redirect target
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        exp_pc = 32'h0; cnt = 0; lat = $urandom_range(0, 3); nacc = 0;
        p_req = 1'b0; p_ack = 1'b0; p_addr = '0; p_clr = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (p_req && !p_ack && !p_clr) begin
                chk("rand_req_held", 32'(f.imem_req), 1);
                chk("rand_addr_stable", f.imem_addr, p_addr);
            end
            clr = $urandom_range(0, 149) == 0;
            redirect = $urandom_range(0, 7) == 0;
            pcsource = 2'($urandom_range(0, 3));
            bpc = $urandom; jpc = $urandom;
            f.out_ready = 1'($urandom_range(0, 1));
            f.imem_ack = f.imem_req && cnt >= lat;
            f.imem_rdata = memf(f.imem_addr);
            e = redirect && pcsource != 2'd0;
            tgt = pcsource == 2'd1 ? bpc : pcsource == 2'd2 ? jpc : 32'h0;
            if (!clr && f.out_valid && f.out_ready && !e) begin
                chk("rand_pc", f.out_pc, exp_pc);
                chk("rand_inst", f.out_inst, memf(exp_pc));
                chk("rand_pc4", f.out_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                nacc++;
            end
            if (clr) exp_pc = 32'h0;
            else if (e) exp_pc = tgt;
            p_req = f.imem_req; p_ack = f.imem_ack; p_addr = f.imem_addr; p_clr = clr;
            tick();
            if (clr || p_ack) begin cnt = 0; lat = $urandom_range(0, 3); end
            else if (p_req) cnt++;
        end
        total++;
        if (nacc < 200) begin
            bad++;
            $display("FAIL rand_progress: got %0d accepted, expected at least 200", nacc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
